// File: rtl/regfile_self_checker.sv
// Register-file self checker: waits for the CPU to settle, then reads each table entry over the
// debug port and compares it with the expected value. Optional macro: REGCHK_CHECK_ALL_EN.
module regfile_self_checker #(
  parameter int WAIT_CYCLES = 80,
  parameter int NUM_CHECKS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  chk_idx,
  input  logic [4:0]  exp_reg,
  input  logic [31:0] exp_val,
  output logic        dbg_re,
  output logic [4:0]  dbg_raddr,
  input  logic [31:0] dbg_rdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [4:0]  fail_idx,
  output logic [31:0] fail_got,
  output logic [5:0]  fail_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ADDR,
    S_CMP,
    S_DONE
  } state_t;

  localparam logic [31:0] WAIT_LAST = 32'(WAIT_CYCLES - 1);
  localparam logic [4:0]  LAST_IDX  = 5'(NUM_CHECKS - 1);
  localparam logic [5:0]  CNT_MAX   = 6'd63;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_next;
  logic [4:0]  r_chk_idx;
  logic [4:0]  w_chk_idx_next;
  logic [4:0]  r_fail_idx;
  logic [4:0]  w_fail_idx_next;
  logic [31:0] r_fail_got;
  logic [31:0] w_fail_got_next;
  logic [5:0]  r_fail_cnt;
  logic [5:0]  w_fail_cnt_next;

  logic w_mismatch;
  logic w_last;
  logic w_stop;

  assign w_mismatch = (dbg_rdata != exp_val);
  assign w_last     = (r_chk_idx == LAST_IDX);

`ifdef REGCHK_CHECK_ALL_EN
  assign w_stop = w_last;
`else
  // Early exit: the first mismatch ends the run.
  assign w_stop = w_last || w_mismatch;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_chk_idx_next  = r_chk_idx;
    w_fail_idx_next = r_fail_idx;
    w_fail_got_next = r_fail_got;
    w_fail_cnt_next = r_fail_cnt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next    = S_WAIT;
          w_cnt_next      = '0;
          w_chk_idx_next  = '0;
          w_fail_idx_next = '0;
          w_fail_got_next = '0;
          w_fail_cnt_next = '0;
        end
      end
      S_WAIT: begin
        if (r_cnt == WAIT_LAST) begin
          w_state_next = S_ADDR;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end
      S_ADDR: begin
        w_state_next = S_CMP;
      end
      S_CMP: begin
        if (w_mismatch) begin
          if (r_fail_cnt != CNT_MAX) begin
            w_fail_cnt_next = r_fail_cnt + 6'd1;
          end
          // Only the first mismatch is captured for diagnosis.
          if (r_fail_cnt == '0) begin
            w_fail_idx_next = r_chk_idx;
            w_fail_got_next = dbg_rdata;
          end
        end
        w_chk_idx_next = r_chk_idx + 5'd1;
        w_state_next   = w_stop ? S_DONE : S_ADDR;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_chk_idx  <= '0;
      r_fail_idx <= '0;
      r_fail_got <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_chk_idx  <= w_chk_idx_next;
      r_fail_idx <= w_fail_idx_next;
      r_fail_got <= w_fail_got_next;
      r_fail_cnt <= w_fail_cnt_next;
    end
  end

  // The table lookup is external, so the read address follows exp_reg for the current index.
  assign dbg_re    = (r_state == S_ADDR);
  assign dbg_raddr = (r_state == S_ADDR) ? exp_reg : 5'd0;
  assign busy      = (r_state == S_WAIT) || (r_state == S_ADDR) || (r_state == S_CMP);
  assign done      = (r_state == S_DONE);
  assign pass      = (r_state == S_DONE) && (r_fail_cnt == '0);
  assign fail      = (r_state == S_DONE) && (r_fail_cnt != '0);
  assign chk_idx   = r_chk_idx;
  assign fail_idx  = r_fail_idx;
  assign fail_got  = r_fail_got;
  assign fail_cnt  = r_fail_cnt;

endmodule

// File: doc/regfile_self_checker.md
REGFILE_SELF_CHECKER -- requirements
Module: regfile_self_checker

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 80: cycles to let the CPU run before checking; legal range >= 1.
REQ-002 SHALL have parameter NUM_CHECKS, default 4: number of expected-value table entries; legal range 1..32.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1: begins a check run when sampled high in IDLE or DONE.
REQ-006 SHALL have port chk_idx  output  5: index of the current table entry, driven to the external expected table.
REQ-007 SHALL have port exp_reg  input  5: register number for entry chk_idx, combinational from the table.
REQ-008 SHALL have port exp_val  input  32: expected value for entry chk_idx, combinational from the table.
REQ-009 SHALL have port dbg_re  output  1: register-file debug read strobe.
REQ-010 SHALL have port dbg_raddr  output  5: register-file debug read address.
REQ-011 SHALL have port dbg_rdata  input  32: debug read data, valid exactly one cycle after dbg_re.
REQ-012 SHALL have port busy  output  1: high in WAIT, ADDR and CMP.
REQ-013 SHALL have port done  output  1: high in DONE.
REQ-014 SHALL have port pass  output  1: high in DONE when no entry mismatched.
REQ-015 SHALL have port fail  output  1: high in DONE when at least one entry mismatched.
REQ-016 SHALL have port fail_idx  output  5: index of the first mismatching entry.
REQ-017 SHALL have port fail_got  output  32: value read for the first mismatching entry.
REQ-018 SHALL have port fail_cnt  output  6: number of mismatching entries.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT, ADDR, CMP, DONE, with all outputs registered or decoded from registered state.
REQ-020 SHALL move IDLE->WAIT or DONE->WAIT on start, clearing the counter, chk_idx, fail, fail_idx, fail_got and fail_cnt.
REQ-021 SHALL stay in WAIT for exactly WAIT_CYCLES cycles, then enter ADDR.
REQ-022 In ADDR, SHALL drive dbg_re=1 and dbg_raddr=exp_reg for one cycle, then enter CMP; outside ADDR, dbg_re=0.
REQ-023 In CMP, SHALL compare dbg_rdata against exp_val over all 32 bits.
REQ-024 On a mismatch in CMP, SHALL increment fail_cnt (saturating at 63); on the first mismatch only, SHALL also latch fail_idx=chk_idx and fail_got=dbg_rdata.
REQ-025 After CMP, SHALL increment chk_idx and go to ADDR if entries remain, else to DONE.
REQ-026 SHALL take 2 cycles per entry; on an all-pass run, done SHALL rise W+2N edges after the edge that samples start.
REQ-027 SHALL ignore start while busy; a start sampled in DONE re-runs from WAIT.
REQ-028 Register 0 entries SHALL be checked like any other register, with no special casing.

Reset
REQ-029 When rst is sampled high, SHALL enter IDLE regardless of state, including mid-run, and abandon any partial results.
REQ-030 While in reset: busy=0, done=0, pass=0, fail=0, dbg_re=0, dbg_raddr=0, chk_idx=0, fail_idx=0, fail_got=0, fail_cnt=0.
REQ-031 If rst and start are both high on the same edge, rst SHALL win.

Configuration
REQ-032 Macro REGCHK_CHECK_ALL_EN SHALL control behaviour after a mismatch.
REQ-033 With REGCHK_CHECK_ALL_EN defined, SHALL check all NUM_CHECKS entries, and fail_cnt SHALL be the total mismatch count.
REQ-034 Without REGCHK_CHECK_ALL_EN, SHALL enter DONE right after the first mismatching CMP; fail_cnt is then 0 or 1, and done SHALL rise W+2(k+1) edges after start for failing entry k.

Verification
REQ-035 Table {x3=13,x4=7,x5=11,x6=2}, regfile matches, W=80, start pulse -> done at edge 88, pass=1, fail=0, fail_cnt=0.
REQ-036 Same table, x5 holds 12 -> fail=1, fail_idx=2, fail_got=12; fail_cnt=1; done at edge 88 with the macro, at edge 86 without it.
REQ-037 x4=8 and x6=3 with the macro defined -> fail_idx=1, fail_got=8, fail_cnt=2, done at edge 88.
REQ-038 rst asserted in the second ADDR cycle -> next cycle IDLE, all outputs zero; a fresh start then gives the REQ-035 result.
REQ-039 start re-pulsed while busy -> ignored, done timing unchanged; start pulsed in DONE -> done drops next cycle and the run repeats.
REQ-040 Every ADDR cycle -> dbg_re=1 and dbg_raddr equal to the table register (3,4,5,6 in order), each read exactly once.
